// File: rtl/t8x8_pkg.sv
// Shared definitions for the t8x8 transpose array, its feeder and their benches.
package t8x8_pkg;

  localparam int unsigned DefN = 8;
  localparam int unsigned DefW = 32;

  typedef logic [DefW-1:0] word_t;

  typedef enum logic {
    LOAD,
    DRAIN
  } state_t;

endpackage

// File: rtl/t8x8_feeder.sv
// Upstream feeder for the t8x8 array: buffers one NxN tile row by row, then replays it
// as a diagonally skewed column stream (lane i lags lane i-1 by one cycle).
module t8x8_feeder
  import t8x8_pkg::*;
#(
  parameter int unsigned N  = DefN,
  parameter int unsigned W  = DefW,
  parameter int unsigned TW = $clog2(2 * N)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic [W-1:0] in_data   [N-1:0],
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] x_out     [N-1:0],
  output logic [N-1:0] v_out,
  output logic [N-1:0] clear_out,
  output logic [N-1:0] shift_out,
  output logic         busy
);

  localparam int unsigned RW = (N > 1) ? $clog2(N) : 1;

  state_t         state_q;
  logic [RW-1:0]  r_q;
  logic [TW-1:0]  t_q;
  // Low for the first cycle after reset so in_ready stays 0 there.
  logic           live_q;
  logic [W-1:0]   tile_q [N][N];

  logic accept;
  logic draining;

  assign draining = (state_q == DRAIN);
  assign in_ready = live_q && enable && (state_q == LOAD);
  assign accept   = in_valid && in_ready;
  assign busy     = draining;

  // Control FSM: row counter in LOAD, drain step counter in DRAIN.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= LOAD;
      r_q     <= '0;
      t_q     <= '0;
      live_q  <= 1'b0;
    end else begin
      live_q <= 1'b1;
      if (enable) begin
        unique case (state_q)
          LOAD: begin
            if (accept) begin
              if (r_q == RW'(N - 1)) begin
                r_q     <= '0;
                t_q     <= '0;
                state_q <= DRAIN;
              end else begin
                r_q <= r_q + RW'(1);
              end
            end
          end
          DRAIN: begin
            if (t_q == TW'(2 * N - 1)) begin
              t_q     <= '0;
              state_q <= LOAD;
            end else begin
              t_q <= t_q + TW'(1);
            end
          end
        endcase
      end
    end
  end

  // Tile storage: one row written per accepted beat, never cleared.
  always_ff @(posedge clk) begin
    if (reset && accept) begin
      for (int j = 0; j < N; j++) begin
        tile_q[r_q][j] <= in_data[j];
      end
    end
  end

  // Per-lane skew mux: lane i outputs column i, row t-i, during steps i..i+N-1.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [TW-1:0] rel;
    logic          win;

    // Wraps to >= N when t < i, so one compare covers both window edges.
    assign rel = t_q - TW'(i);
    assign win = draining && (rel < TW'(N));

    // x_out ignores enable so it holds through a stall.
    assign x_out[i]     = win ? tile_q[rel[RW-1:0]][i] : '0;
    assign v_out[i]     = win && enable;
    assign clear_out[i] = draining && enable && (t_q == TW'(i));
    assign shift_out[i] = draining && enable && (t_q == TW'(i + N));
  end

endmodule

// File: tb/tb_t8x8_feeder.sv
// Scoreboard bench for t8x8_feeder: stimulus queues expected drain steps, a monitor
// pops and compares them on every enabled busy cycle.
module tb_t8x8_feeder;
  import t8x8_pkg::*;

  localparam int unsigned N = DefN;
  localparam int unsigned W = DefW;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         enable = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         busy;
  logic [W-1:0] in_data [N-1:0];
  logic [W-1:0] x_out   [N-1:0];
  logic [N-1:0] v_out;
  logic [N-1:0] clear_out;
  logic [N-1:0] shift_out;

  always #5 clk = ~clk;

  t8x8_feeder #(
    .N(N),
    .W(W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x_out    (x_out),
    .v_out    (v_out),
    .clear_out(clear_out),
    .shift_out(shift_out),
    .busy     (busy)
  );

  typedef struct packed {
    logic [7:0]     t;
    logic [N-1:0]   v;
    logic [N-1:0]   c;
    logic [N-1:0]   s;
    logic [N*W-1:0] x;
  } step_t;

  step_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int acc_cnt  = 0;
  int last_acc_cyc = 0;
  int last_t15_cyc = 0;
  int steps_seen = 0;
  int busy_run = 0;
  int last_busy_run = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] elem(input logic [31:0] base, input int r, input int c);
    return base | 32'(r << 8) | 32'(c);
  endfunction

  // Expected drain sequence for a tile whose elements are base | RR<<8 | CC.
  task automatic push_tile(input logic [31:0] base);
    step_t s;
    for (int t = 0; t < 2 * N; t++) begin
      s = '0;
      s.t = t[7:0];
      for (int i = 0; i < N; i++) begin
        if (t >= i && t <= i + N - 1) begin
          s.v[i] = 1'b1;
          s.x[i*W +: W] = elem(base, t - i, i);
        end
        if (t == i) s.c[i] = 1'b1;
        if (t == i + N) s.s[i] = 1'b1;
      end
      exp_q.push_back(s);
    end
  endtask

  task automatic send_row(input int r, input logic [31:0] base);
    bit ok;
    for (int j = 0; j < N; j++) in_data[j] = elem(base, r, j);
    in_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (!ok) check($sformatf("row%0d_accept_timeout", r), 32'd0, 32'd1);
  endtask

  task automatic send_tile(input logic [31:0] base, input bit gaps);
    for (int r = 0; r < N; r++) begin
      send_row(r, base);
      if (gaps && r != N - 1) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic wait_drain(input string name);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check({name, "_drain_timeout"}, 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  // Monitor: accepted-row tracking and drain-step scoreboard.
  initial begin
    step_t e;
    forever begin
      @(negedge clk);
      if (reset && in_valid && in_ready) begin
        acc_cnt++;
        last_acc_cyc = cyc;
      end
      if (busy) busy_run++;
      else if (busy_run != 0) begin
        last_busy_run = busy_run;
        busy_run = 0;
      end
      if (reset && enable && busy) begin
        steps_seen++;
        if (exp_q.size() == 0) begin
          check("unexpected_drain_step", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("v_out@t%0d", e.t), 32'(v_out), 32'(e.v));
          check($sformatf("clear_out@t%0d", e.t), 32'(clear_out), 32'(e.c));
          check($sformatf("shift_out@t%0d", e.t), 32'(shift_out), 32'(e.s));
          check($sformatf("in_ready@t%0d", e.t), 32'(in_ready), 32'd0);
          for (int i = 0; i < N; i++) begin
            check($sformatf("x_out[%0d]@t%0d", i, e.t), x_out[i], e.x[i*W +: W]);
          end
          if (e.t == 8'd15) last_t15_cyc = cyc;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int acc0;
    int steps0;
    int t15_a;
    for (int j = 0; j < N; j++) in_data[j] = elem(32'h0, 0, j);

    // Reset held with a pending row.
    reset = 1'b0;
    enable = 1'b1;
    in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_v_out", 32'(v_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_clear_shift", 32'({clear_out, shift_out}), 32'd0);
    check("rst_x_out0", x_out[0], 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("release_in_ready", 32'(in_ready), 32'd1);

    // Full tile, no gaps, with hand-computed spot checks.
    push_tile(32'h0);
    acc0 = acc_cnt;
    send_tile(32'h0, 1'b0);
    check("full_accepts", 32'(acc_cnt - acc0), 32'd8);
    check("full_t0_busy", 32'(busy), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("t3_v_out", 32'(v_out), 32'h0F);
    check("t3_x_out2", x_out[2], 32'h0000_0102);
    check("t3_clear_out", 32'(clear_out), 32'h08);
    repeat (12) @(posedge clk);
    #1;
    check("t15_shift_out", 32'(shift_out), 32'h80);
    wait_drain("full");
    check("full_busy_len", 32'(last_busy_run), 32'd16);

    // Same tile with handshake gaps.
    push_tile(32'h0);
    acc0 = acc_cnt;
    send_tile(32'h0, 1'b1);
    check("gap_accepts", 32'(acc_cnt - acc0), 32'd8);
    wait_drain("gap");
    check("gap_busy_len", 32'(last_busy_run), 32'd16);

    // Enable stall of 3 cycles at t=5.
    push_tile(32'h0002_0000);
    steps0 = steps_seen;
    send_tile(32'h0002_0000, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_vcs", 32'({v_out, clear_out, shift_out}), 32'd0);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_busy", 32'(busy), 32'd1);
      check("stall_x_out0", x_out[0], 32'h0002_0500);
      check("stall_x_out5", x_out[5], 32'h0002_0005);
      check("stall_x_out6", x_out[6], 32'h0);
      @(posedge clk);
    end
    #1;
    enable = 1'b1;
    wait_drain("stall");
    check("stall_steps", 32'(steps_seen - steps0), 32'd16);
    check("stall_busy_len", 32'(last_busy_run), 32'd19);

    // Reset in the middle of a drain, then a fresh tile.
    push_tile(32'h0003_0000);
    send_tile(32'h0003_0000, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_q.delete();
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_vcs", 32'({v_out, clear_out, shift_out}), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    check("midrst_x_out0", x_out[0], 32'd0);
    push_tile(32'h0004_0000);
    send_tile(32'h0004_0000, 1'b0);
    check("fresh_t0_clear", 32'(clear_out), 32'h01);
    wait_drain("fresh");

    // Back-to-back tiles with in_valid held high.
    push_tile(32'h0005_0000);
    push_tile(32'h0006_0000);
    send_tile(32'h0005_0000, 1'b0);
    send_row(0, 32'h0006_0000);
    t15_a = last_t15_cyc;
    check("b2b_next_accept_gap", 32'(last_acc_cyc - t15_a), 32'd1);
    for (int r = 1; r < N; r++) send_row(r, 32'h0006_0000);
    wait_drain("b2b");

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/t8x8_feeder.md
Name: t8x8_feeder

Overview:
- Upstream stage of the t8x8 transpose array.
- Accepts an NxN tile of W-bit words one row per beat over a valid/ready handshake, then buffers it.
- Replays the tile into the array's per-lane x_in/v_in/clear_in/shift inputs as a diagonally skewed column stream: lane i lags lane i-1 by one cycle.
- Single-tile buffer: load and drain alternate; they do not overlap.

Parameters:
- N, 8, tile dimension and lane count; must match t8x8.
- W, 32, data word width.
- TW, $clog2(2*N), width of the drain step counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset.
- enable  input  1  global advance; same net as the t8x8 enable.
- in_data  input  [W-1:0] x N (unpacked [N-1:0])  one tile row; element j is column j.
- in_valid  input  1  in_data holds a valid row.
- in_ready  output  1  feeder accepts a row this cycle.
- x_out  output  [W-1:0] x N  to t8x8 x_in.
- v_out  output  N  per-lane valid, to t8x8 v_in.
- clear_out  output  N  per-lane start-of-tile pulse, to t8x8 clear_in.
- shift_out  output  N  per-lane end-of-tile pulse, to t8x8 shift.
- busy  output  1  high in DRAIN state.

Behaviour:
- States: LOAD, DRAIN. Reset state is LOAD.
- Counters: row counter r (0..N-1), drain step t (0..2N-1).
- Reset (reset==0 at an edge):
  - state=LOAD, r=0, t=0.
  - All outputs 0 the following cycle, including in_ready and busy.
  - Tile storage is not cleared.
  - Reset mid-DRAIN abandons the tile; no further clear/shift pulses are issued.
- enable==0:
  - No state, counter or storage changes.
  - in_ready=0.
  - v_out, clear_out and shift_out forced to 0; x_out holds its value.
  - Drain resumes at the same t when enable returns.
- LOAD:
  - in_ready = enable.
  - On in_valid && in_ready: tile[r][j] <= in_data[j] for all j; r increments.
  - Accepting row N-1: r<=0, state<=DRAIN, t<=0.
  - in_valid with in_ready low: row is not consumed; the source must hold it.
- DRAIN, step t, visible combinationally from registered state in the cycle where t holds:
  - v_out[i] = (i <= t <= i+N-1).
  - x_out[i] = tile[t-i][i] when v_out[i], else 0.
  - clear_out[i] = (t == i); coincides with lane i's first valid element.
  - shift_out[i] = (t == i+N); one cycle after lane i's last element.
  - t increments when enable is high. At t==2N-1: state<=LOAD, t<=0.
  - in_ready=0, busy=1.
- Timing:
  - If the last row is accepted at cycle A, step t appears at cycle A+1+t.
  - Drain lasts exactly 2N enabled cycles.
  - The first row of the next tile can be accepted at cycle A+2N+1.
- Simultaneous events:
  - reset==0 overrides enable and handshake.
  - in_valid during DRAIN is ignored (in_ready=0).
- All outputs 0 in LOAD except in_ready; x_out is 0 in LOAD.

Decomposition:
- Package t8x8_pkg: N and W defaults, typedef word_t = logic [W-1:0], and the state enum {LOAD, DRAIN}. Shared with t8x8 and its benches.
- No sub-module. Storage, counters and the per-lane skew mux are a flat generate loop over lanes.

Test Plan:
- Reset: hold reset=0 for 2 cycles with in_valid=1 → in_ready=0, v_out=0, busy=0. First row is accepted on the first enabled cycle after release.
- Full tile: rows with element value 32'h0000_RRCC, enable=1 → checks:
  - in_ready high for 8 beats.
  - At t=3: v_out=8'b0000_1111, x_out[2]=32'h0000_0102, clear_out=8'b0000_1000.
  - At t=15: shift_out=8'b1000_0000.
  - busy lasts 16 cycles.
- Handshake gaps: in_valid toggled 1,0,1,… → exactly 8 accepted rows. Tile contents unchanged and output sequence identical to the gap-free case.
- Enable stall: drop enable for 3 cycles at t=5 → v/clear/shift=0 and x_out held during the stall. Resumes at t=5; total drain = 16 enabled cycles.
- Reset mid-drain: reset=0 at t=6 → next cycle all outputs 0 and state LOAD. A fresh tile then drains correctly, with clear_out[0] at its t=0.
- Back-to-back tiles: two tiles streamed with in_valid held high → second tile's first row accepted exactly 1 cycle after the first tile's t=15. No lane mixes data from both tiles.
